// File: rtl/ila_trig_buffer.sv
// Purpose : trigger-qualified sample capture buffer (logic-analyser style), optional ring mode via ILA_CIRCULAR_BUFFER_EN.
// Latency : a captured sample is readable the cycle after its write; read data is registered, one cycle after index.
// Backpressure: none; linear mode drops writes once full, ring mode overwrites the oldest sample.
module ila_trig_buffer #(
    parameter int DATA_W   = 8,
    parameter int BUFFER_W = 8,
    parameter int TRIG_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_soft,
    input  logic                enabled,
    input  logic [DATA_W-1:0]   signal,
    input  logic [TRIG_W-1:0]   trigger,
    input  logic [TRIG_W-1:0]   trigger_type,
    input  logic [TRIG_W-1:0]   negate_trigger,
    input  logic [TRIG_W-1:0]   trigger_mask,
    input  logic                reduce_type,
    input  logic                circular,
    input  logic [BUFFER_W-1:0] index,
    output logic [BUFFER_W:0]   samples,
    output logic [DATA_W-1:0]   value,
    output logic                full
);

    localparam int                  DEPTH     = 1 << BUFFER_W;
    localparam logic [BUFFER_W:0]   DEPTH_CNT = (BUFFER_W + 1)'(DEPTH);
    localparam logic [BUFFER_W:0]   CNT_ONE   = (BUFFER_W + 1)'(1);
    localparam logic [BUFFER_W-1:0] PTR_ONE   = BUFFER_W'(1);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [BUFFER_W-1:0] wr_ptr;
    logic [TRIG_W-1:0]   t_prev;

    logic                clr;
    logic [TRIG_W-1:0]   t_cur;
    logic [TRIG_W-1:0]   t_det;
    logic                trig_act;
    logic                circ_mode;
    logic                wr_en;
    logic [BUFFER_W-1:0] rd_addr;
    logic                rd_valid;

    // Both reset sources behave identically and win over any capture in the same cycle.
    assign clr = rst | rst_soft;

`ifdef ILA_CIRCULAR_BUFFER_EN
    assign circ_mode = circular;
`else
    // Linear-only build: the mode input is accepted but has no effect.
    assign circ_mode = 1'b0;
    logic unused_circular;
    assign unused_circular = circular;
`endif

    // Per-bit trigger detection, then mask and reduce; an empty mask never fires.
    always_comb begin
        t_cur    = trigger ^ negate_trigger;
        t_det    = (trigger_type & t_cur & ~t_prev) | (~trigger_type & t_cur);
        trig_act = 1'b0;
        if (|trigger_mask) begin
            if (reduce_type)
                trig_act = &(t_det | ~trigger_mask);
            else
                trig_act = |(t_det & trigger_mask);
        end
    end

    assign full  = (samples == DEPTH_CNT);
    assign wr_en = enabled & trig_act & (~full | circ_mode);

    // Map the logical read index to a physical slot; in a wrapped ring index 0 is the oldest sample.
    always_comb begin
`ifdef ILA_CIRCULAR_BUFFER_EN
        rd_addr = (circ_mode & full) ? (wr_ptr + index) : index;
`else
        rd_addr = index;
`endif
        rd_valid = ({1'b0, index} < samples);
    end

    // Capture storage; never cleared, stale slots are hidden by the sample count.
    always_ff @(posedge clk) begin
        if (wr_en && !clr)
            mem[wr_ptr] <= signal;
    end

    // Control state, edge history and registered read port (reads old data on a same-slot write).
    always_ff @(posedge clk) begin
        if (clr) begin
            samples <= '0;
            wr_ptr  <= '0;
            t_prev  <= '0;
            value   <= '0;
        end else begin
            t_prev <= t_cur;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (!full)
                    samples <= samples + CNT_ONE;
            end
            value <= rd_valid ? mem[rd_addr] : '0;
        end
    end

endmodule
